// File: rtl/mpsoc_wb_uart_rx_framer.sv
// UART receive framer: 16x oversampled deframing of 5..8-bit characters with
// optional parity, pushing {data[7:0], break, parity_err, framing_err} to the
// receive FIFO, plus the four-character receive timeout counter.
// Optional feature macro: UART_RX_MAJORITY_EN (3-sample majority bit decision).
module mpsoc_wb_uart_rx_framer #(
  parameter int unsigned FIFO_WIDTH     = 11,
  parameter int unsigned FIFO_COUNTER_W = 5,
  parameter int unsigned TOUT_W         = 10,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic                      clk,
  input  logic                      wb_rst_i,
  input  logic                      enable,
  input  logic                      srx_pad_i,
  input  logic [7:0]                lcr,
  input  logic                      rx_reset,
  input  logic [FIFO_COUNTER_W-1:0] rf_count,
  input  logic                      rf_pop,
  output logic                      rf_push,
  output logic [FIFO_WIDTH-1:0]     rf_data_in,
  output logic [2:0]                rstate,
  output logic                      timeout
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_PUSH      = 3'd5,
    S_WAIT_HIGH = 3'd6
  } state_t;

  state_t                  r_state, w_state;
  logic [SYNC_STAGES-1:0]  r_sync;
  logic [3:0]              r_cnt, w_cnt;
  logic [2:0]              r_bitcnt, w_bitcnt;
  logic [7:0]              r_shift, w_shift;
  logic [5:0]              r_cfg, w_cfg;
  logic                    r_pe, w_pe;
  logic                    r_allz, w_allz;
  logic [FIFO_WIDTH-1:0]   r_data, w_data;
  logic [TOUT_W-1:0]       r_counter_t;
  logic [TOUT_W-1:0]       w_reload;
  logic [3:0]              w_bits;
  logic                    w_rx, w_bit, w_samp, w_exp_par, w_brk, w_unused;

  assign w_rx     = r_sync[SYNC_STAGES-1];
  assign w_unused = &{1'b0, lcr[7:6]};

`ifdef UART_RX_MAJORITY_EN
  logic r_v6, r_v7;

  // Capture the two early samples of each bit for the cnt==8 majority vote
  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      r_v6 <= 1'b1;
      r_v7 <= 1'b1;
    end else if (enable) begin
      if (r_cnt == 4'd6) r_v6 <= w_rx;
      if (r_cnt == 4'd7) r_v7 <= w_rx;
    end
  end

  assign w_samp = enable && (r_cnt == 4'd8);
  assign w_bit  = (r_v6 & r_v7) | (r_v6 & w_rx) | (r_v7 & w_rx);
`else
  assign w_samp = enable && (r_cnt == 4'd7);
  assign w_bit  = w_rx;
`endif

  // Expected parity from the frozen frame config and received data bits
  assign w_exp_par = r_cfg[5] ? ~r_cfg[4] : (r_cfg[4] ? ^r_shift : ~^r_shift);

  // Synchronise the asynchronous serial input; idles high
  always_ff @(posedge clk) begin
    if (wb_rst_i) r_sync <= '1;
    else          r_sync <= {r_sync[SYNC_STAGES-2:0], srx_pad_i};
  end

  // Receiver state and per-frame datapath registers
  always_ff @(posedge clk) begin
    if (wb_rst_i || rx_reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_cfg    <= '0;
      r_pe     <= 1'b0;
      r_allz   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_cnt    <= w_cnt;
      r_bitcnt <= w_bitcnt;
      r_shift  <= w_shift;
      r_cfg    <= w_cfg;
      r_pe     <= w_pe;
      r_allz   <= w_allz;
    end
  end

  // Push word holds its last value; only a full reset clears it
  always_ff @(posedge clk) begin
    if (wb_rst_i) r_data <= '0;
    else          r_data <= w_data;
  end

  // Next-state and datapath decode
  always_comb begin
    w_state  = r_state;
    w_cnt    = enable ? r_cnt + 4'd1 : r_cnt;
    w_bitcnt = r_bitcnt;
    w_shift  = r_shift;
    w_cfg    = r_cfg;
    w_pe     = r_pe;
    w_allz   = r_allz;
    w_data   = r_data;
    w_brk    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt = r_cnt;
        if (enable && !w_rx) begin
          w_state = S_START;
          w_cnt   = '0;
          w_cfg   = lcr[5:0];
          w_shift = '0;
          w_pe    = 1'b0;
          w_allz  = 1'b1;
        end
      end
      S_START: begin
        if (w_samp && w_bit) begin
          w_state = S_IDLE;
        end else if (enable && r_cnt == 4'd15) begin
          w_state  = S_DATA;
          w_bitcnt = '0;
        end
      end
      S_DATA: begin
        if (w_samp) begin
          w_shift[r_bitcnt] = w_bit;
          if (w_bit) w_allz = 1'b0;
        end
        if (enable && r_cnt == 4'd15) begin
          // Last data bit index is wlen-1 = lcr[1:0]+4
          if (r_bitcnt == {1'b1, r_cfg[1:0]}) w_state = r_cfg[3] ? S_PARITY : S_STOP;
          else                                w_bitcnt = r_bitcnt + 3'd1;
        end
      end
      S_PARITY: begin
        if (w_samp) begin
          w_pe = (w_bit != w_exp_par);
          if (w_bit) w_allz = 1'b0;
        end
        if (enable && r_cnt == 4'd15) w_state = S_STOP;
      end
      S_STOP: begin
        if (w_samp) begin
          // r_allz is reused as the break marker while in PUSH
          w_brk   = r_allz & ~w_bit;
          w_allz  = w_brk;
          w_data  = {(w_brk ? 8'h00 : r_shift), w_brk, r_pe, ~w_bit};
          w_state = S_PUSH;
        end
      end
      S_PUSH: begin
        w_cnt   = r_cnt;
        w_state = r_allz ? S_WAIT_HIGH : S_IDLE;
      end
      S_WAIT_HIGH: begin
        w_cnt = r_cnt;
        if (enable && w_rx) w_state = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
  end

  // Four character times in ticks: 64 * (start + wlen + parity + stops) - 1
  assign w_bits   = 4'd6 + {2'b00, lcr[1:0]} + {3'b000, lcr[3]} + (lcr[2] ? 4'd2 : 4'd1);
  assign w_reload = TOUT_W'({w_bits, 6'd0}) - TOUT_W'(1);

  // Character timeout counter
  always_ff @(posedge clk) begin
    if (wb_rst_i || rx_reset)
      r_counter_t <= '1;
    else if (rf_push || rf_pop || rf_count == '0)
      r_counter_t <= w_reload;
    else if (enable && r_counter_t != '0)
      r_counter_t <= r_counter_t - TOUT_W'(1);
  end

  assign rf_push    = (r_state == S_PUSH);
  assign rf_data_in = r_data;
  assign rstate     = r_state;
  assign timeout    = (r_counter_t == '0) && (rf_count != '0);

endmodule
